// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 asynchronous receiver with oversampling and a small
// first-word-fall-through FIFO.
//
// Optional build macro: UART_RX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit (11-bit frame). When undefined, PARITY_ERR
// is tied low.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   EN         receiver enable; low aborts any frame, FIFO/flags retained
//   RX         asynchronous serial line, idles high
//   BAUD_DIV   oversample tick every BAUD_DIV+1 clocks
//   POP        one-cycle read strobe for the FIFO head
//   CLR_ERR    clears the sticky error flags
//   RDATA      FIFO head (0 when empty)
//   RX_READY   FIFO not empty
//   RX_FULL    FIFO holds DEPTH entries
//   OVERRUN    sticky: a good byte was dropped because the FIFO was full
//   FRAME_ERR  sticky: stop bit sampled low
//   BUSY       receiver is inside a frame
//   PARITY_ERR sticky parity error (parity build only)
module uart_rx_fifo #(
  parameter int DEPTH      = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DIVW       = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic            RX,
  input  logic [DIVW-1:0] BAUD_DIV,
  input  logic            POP,
  input  logic            CLR_ERR,
  output logic [7:0]      RDATA,
  output logic            RX_READY,
  output logic            RX_FULL,
  output logic            OVERRUN,
  output logic            FRAME_ERR,
  output logic            BUSY,
  output logic            PARITY_ERR
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int NW = AW + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] FULL_CNT  = NW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic            sync1_r, rxs_r, rxs_d_r;
  logic [DIVW-1:0] baud_cnt_r;
  logic            tick_s;

  state_t          state_r, state_nxt;
  logic [CW-1:0]   samp_r, samp_nxt;
  logic [2:0]      bit_r, bit_nxt;
  logic [7:0]      shift_r, shift_nxt;
  logic            stop_ok_s, frame_set_s;

  logic            byte_ok_s, push_s, pop_s, ovr_set_s;
  logic [7:0]      mem_r [DEPTH];
  logic [AW-1:0]   wr_r, rd_r, wr_nxt, rd_nxt;
  logic [NW-1:0]   cnt_r, cnt_nxt;
  logic [7:0]      head_nxt;

  logic [7:0]      rdata_r;
  logic            ready_r, full_r, ovr_r, fe_r, busy_r;

`ifdef UART_RX_PARITY_EN
  logic            par_bad_r, par_bad_nxt, par_set_s, par_err_r;

  // Even parity holds when data bits plus parity bit XOR to zero.
  function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
    return ~(^{data, par});
  endfunction
`endif

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
      rxs_d_r <= 1'b1;
    end else begin
      sync1_r <= RX;
      rxs_r   <= sync1_r;
      rxs_d_r <= rxs_r;
    end
  end

  // >= rather than == so a divisor lowered mid-count still wraps at once.
  assign tick_s = EN && (baud_cnt_r >= BAUD_DIV);

  // Oversample baud counter, held at zero while disabled.
  always_ff @(posedge CLK) begin
    if (RST || !EN) begin
      baud_cnt_r <= {DIVW{1'b0}};
    end else if (tick_s) begin
      baud_cnt_r <= {DIVW{1'b0}};
    end else begin
      baud_cnt_r <= baud_cnt_r + DIVW'(1'b1);
    end
  end

  // Receive FSM next-state, shift register and stop-bit decision.
  always_comb begin
    state_nxt   = state_r;
    samp_nxt    = samp_r;
    bit_nxt     = bit_r;
    shift_nxt   = shift_r;
    stop_ok_s   = 1'b0;
    frame_set_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt = par_bad_r;
    par_set_s   = 1'b0;
`endif
    if (!EN) begin
      state_nxt = S_IDLE;
      samp_nxt  = {CW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (rxs_d_r && !rxs_r) begin
            state_nxt = S_START;
            samp_nxt  = {CW{1'b0}};
`ifdef UART_RX_PARITY_EN
            par_bad_nxt = 1'b0;
`endif
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_START: begin
          if (tick_s && samp_r == HALF_LAST) begin
            // A line back high at mid start bit was only a glitch.
            if (!rxs_r) begin
              state_nxt = S_DATA;
              samp_nxt  = {CW{1'b0}};
              bit_nxt   = 3'd0;
            end else begin
              state_nxt = S_IDLE;
            end
          end else if (tick_s) begin
            samp_nxt = samp_r + CW'(1'b1);
          end else begin
            samp_nxt = samp_r;
          end
        end
        S_DATA: begin
          if (tick_s && samp_r == BIT_LAST) begin
            shift_nxt = {rxs_r, shift_r[7:1]};
            samp_nxt  = {CW{1'b0}};
            if (bit_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = S_PARITY;
`else
              state_nxt = S_STOP;
`endif
              bit_nxt = 3'd0;
            end else begin
              bit_nxt = bit_r + 3'd1;
            end
          end else if (tick_s) begin
            samp_nxt = samp_r + CW'(1'b1);
          end else begin
            samp_nxt = samp_r;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick_s && samp_r == BIT_LAST) begin
            par_set_s   = ~even_parity_ok(shift_r, rxs_r);
            par_bad_nxt = par_set_s;
            state_nxt   = S_STOP;
            samp_nxt    = {CW{1'b0}};
          end else if (tick_s) begin
            samp_nxt = samp_r + CW'(1'b1);
          end else begin
            samp_nxt = samp_r;
          end
        end
`endif
        S_STOP: begin
          if (tick_s && samp_r == BIT_LAST) begin
            stop_ok_s   = rxs_r;
            frame_set_s = ~rxs_r;
            state_nxt   = S_IDLE;
            samp_nxt    = {CW{1'b0}};
          end else if (tick_s) begin
            samp_nxt = samp_r + CW'(1'b1);
          end else begin
            samp_nxt = samp_r;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          samp_nxt  = {CW{1'b0}};
        end
      endcase
    end
  end

  // Receive FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_IDLE;
      samp_r  <= {CW{1'b0}};
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
`ifdef UART_RX_PARITY_EN
      par_bad_r <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt;
      samp_r  <= samp_nxt;
      bit_r   <= bit_nxt;
      shift_r <= shift_nxt;
`ifdef UART_RX_PARITY_EN
      par_bad_r <= par_bad_nxt;
`endif
    end
  end

`ifdef UART_RX_PARITY_EN
  assign byte_ok_s = stop_ok_s && !par_bad_r;
`else
  assign byte_ok_s = stop_ok_s;
`endif

  // FIFO control; a pop in the stop-sample cycle makes room for the push.
  always_comb begin
    pop_s     = POP && (cnt_r != {NW{1'b0}});
    push_s    = byte_ok_s && ((cnt_r != FULL_CNT) || pop_s);
    ovr_set_s = byte_ok_s && (cnt_r == FULL_CNT) && !pop_s;
    if (push_s) begin
      wr_nxt = wr_r + AW'(1'b1);
    end else begin
      wr_nxt = wr_r;
    end
    if (pop_s) begin
      rd_nxt = rd_r + AW'(1'b1);
    end else begin
      rd_nxt = rd_r;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_nxt = cnt_r + NW'(1'b1);
      2'b01:   cnt_nxt = cnt_r - NW'(1'b1);
      default: cnt_nxt = cnt_r;
    endcase
    // The new head may be the byte being written this very cycle.
    if (cnt_nxt == {NW{1'b0}}) begin
      head_nxt = 8'h00;
    end else if (push_s && rd_nxt == wr_r) begin
      head_nxt = shift_r;
    end else begin
      head_nxt = mem_r[rd_nxt];
    end
  end

  // FIFO storage; contents are don't-care until pointed at by the count.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_r] <= shift_r;
    end
  end

  // FIFO pointers, count and registered status/head outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_r    <= {AW{1'b0}};
      rd_r    <= {AW{1'b0}};
      cnt_r   <= {NW{1'b0}};
      rdata_r <= 8'h00;
      ready_r <= 1'b0;
      full_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      wr_r    <= wr_nxt;
      rd_r    <= rd_nxt;
      cnt_r   <= cnt_nxt;
      rdata_r <= head_nxt;
      ready_r <= (cnt_nxt != {NW{1'b0}});
      full_r  <= (cnt_nxt == FULL_CNT);
      busy_r  <= (state_nxt != S_IDLE);
    end
  end

  // Sticky error flags; a set event beats a simultaneous clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovr_r <= 1'b0;
      fe_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_r <= 1'b0;
`endif
    end else begin
      if (ovr_set_s) begin
        ovr_r <= 1'b1;
      end else if (CLR_ERR) begin
        ovr_r <= 1'b0;
      end else begin
        ovr_r <= ovr_r;
      end
      if (frame_set_s) begin
        fe_r <= 1'b1;
      end else if (CLR_ERR) begin
        fe_r <= 1'b0;
      end else begin
        fe_r <= fe_r;
      end
`ifdef UART_RX_PARITY_EN
      if (par_set_s) begin
        par_err_r <= 1'b1;
      end else if (CLR_ERR) begin
        par_err_r <= 1'b0;
      end else begin
        par_err_r <= par_err_r;
      end
`endif
    end
  end

  assign RDATA     = rdata_r;
  assign RX_READY  = ready_r;
  assign RX_FULL   = full_r;
  assign OVERRUN   = ovr_r;
  assign FRAME_ERR = fe_r;
  assign BUSY      = busy_r;
`ifdef UART_RX_PARITY_EN
  assign PARITY_ERR = par_err_r;
`else
  assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=4, OVERSAMPLE=16).
// All stimulus is driven and all outputs sampled 1 time unit after a rising
// clock edge. Frames are built bit by bit; the edge counter n inside
// send_byte counts rising edges since the start bit was put on the line.
module tb_uart_rx_fifo;

  logic       CLK, RST, EN, RX, POP, CLR_ERR;
  logic [7:0] BAUD_DIV;
  logic [7:0] RDATA;
  logic       RX_READY, RX_FULL, OVERRUN, FRAME_ERR, BUSY, PARITY_ERR;

  int total = 0;
  int bad   = 0;

`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // 2-flop sync + edge detect (3), 8 ticks to mid start bit, 16 per later bit.
  localparam int STOP_EDGE = 155 + 16 * (NB - 10);
  localparam int RDY_LO    = 152 + 16 * (NB - 10);
  localparam int RDY_HI    = 158 + 16 * (NB - 10);

  int   rdy_at;
  logic busy_pre, busy_post;

  uart_rx_fifo #(.DEPTH(4), .OVERSAMPLE(16), .DIVW(8)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .RX(RX), .BAUD_DIV(BAUD_DIV),
    .POP(POP), .CLR_ERR(CLR_ERR), .RDATA(RDATA), .RX_READY(RX_READY),
    .RX_FULL(RX_FULL), .OVERRUN(OVERRUN), .FRAME_ERR(FRAME_ERR),
    .BUSY(BUSY), .PARITY_ERR(PARITY_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drives one frame; optional one-cycle POP / CLR_ERR / RST pulses and an EN
  // drop at given edge numbers (-1 = never). Reports the first 0->1 edge of
  // RX_READY and BUSY just before / one edge after the EN drop.
  task automatic send_byte(input logic [7:0] d, input logic stop_b,
                           input logic par_flip, input int cpb,
                           input int pop_at, input int clr_at,
                           input int en_off_at, input int rst_at);
    logic [10:0] bits;
    logic        rdy0;
    int          n;
    bits      = 11'h7FF;
    bits[0]   = 1'b0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9]  = (^d) ^ par_flip;
    bits[10] = stop_b;
`else
    bits[9]  = stop_b;
`endif
    rdy_at    = -1;
    busy_pre  = 1'b0;
    busy_post = 1'b0;
    rdy0      = RX_READY;
    n         = 0;
    for (int b = 0; b < NB; b++) begin
      RX = bits[b];
      for (int c = 0; c < cpb; c++) begin
        @(posedge CLK);
        #1;
        n++;
        if (rdy_at < 0 && !rdy0 && RX_READY) rdy_at = n;
        POP     = (n == pop_at);
        CLR_ERR = (n == clr_at);
        RST     = (n == rst_at);
        if (n == en_off_at) begin
          busy_pre = BUSY;
          EN       = 1'b0;
        end
        if (n == en_off_at + 1) busy_post = BUSY;
      end
    end
    POP = 1'b0; CLR_ERR = 1'b0; RST = 1'b0;
  endtask

  task automatic pulse_pop();
    POP = 1'b1; tick(1); POP = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b0; RX = 1'b1; POP = 1'b0; CLR_ERR = 1'b0; BAUD_DIV = 8'd0;
    tick(3);
    total++;
    if (RDATA !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h want 00", RDATA); end
    total++;
    if ({RX_READY, RX_FULL, OVERRUN, FRAME_ERR, BUSY, PARITY_ERR} !== 6'b000000) begin
      bad++; $display("FAIL reset_flags: got %b want 000000",
                      {RX_READY, RX_FULL, OVERRUN, FRAME_ERR, BUSY, PARITY_ERR});
    end
    RST = 1'b0; EN = 1'b1;
    tick(4);
  endtask

  task automatic test_clean_byte();
    send_byte(8'hA5, 1'b1, 1'b0, 16, -1, -1, -1, -1);
    tick(4);
    total++;
    if (rdy_at < RDY_LO || rdy_at > RDY_HI) begin
      bad++; $display("FAIL clean_latency: got %0d want %0d..%0d", rdy_at, RDY_LO, RDY_HI);
    end
    total++;
    if (RDATA !== 8'hA5) begin bad++; $display("FAIL clean_rdata: got %h want a5", RDATA); end
    total++;
    if (BUSY !== 1'b0 || FRAME_ERR !== 1'b0) begin
      bad++; $display("FAIL clean_status: got busy=%b fe=%b want 0 0", BUSY, FRAME_ERR);
    end
    pulse_pop();
    total++;
    if (RX_READY !== 1'b0) begin bad++; $display("FAIL clean_pop: got ready=%b want 0", RX_READY); end
    pulse_pop();
    tick(1);
    total++;
    if (RX_READY !== 1'b0 || RX_FULL !== 1'b0 || RDATA !== 8'h00) begin
      bad++; $display("FAIL pop_empty: got ready=%b full=%b rdata=%h want 0 0 00",
                      RX_READY, RX_FULL, RDATA);
    end
  endtask

  task automatic test_fifo_fill();
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i), 1'b1, 1'b0, 16, -1, -1, -1, -1);
      tick(4);
      if (i == 3) begin
        total++;
        if (RX_FULL !== 1'b0) begin bad++; $display("FAIL fill_3: got full=%b want 0", RX_FULL); end
      end
      if (i == 4) begin
        total++;
        if (RX_FULL !== 1'b1 || OVERRUN !== 1'b0) begin
          bad++; $display("FAIL fill_4: got full=%b ovr=%b want 1 0", RX_FULL, OVERRUN);
        end
      end
      if (i == 5) begin
        total++;
        if (OVERRUN !== 1'b1) begin bad++; $display("FAIL fill_overrun: got %b want 1", OVERRUN); end
      end
    end
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (RDATA !== 8'(i)) begin bad++; $display("FAIL fill_pop%0d: got %h want %h", i, RDATA, 8'(i)); end
      pulse_pop();
      if (i == 1) begin
        total++;
        if (RX_FULL !== 1'b0) begin bad++; $display("FAIL fill_unfull: got full=%b want 0", RX_FULL); end
      end
    end
    total++;
    if (RX_READY !== 1'b0) begin bad++; $display("FAIL fill_empty: got ready=%b want 0", RX_READY); end
    CLR_ERR = 1'b1; tick(1); CLR_ERR = 1'b0;
    total++;
    if (OVERRUN !== 1'b0) begin bad++; $display("FAIL fill_clr: got ovr=%b want 0", OVERRUN); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      send_byte(8'(i), 1'b1, 1'b0, 16, -1, -1, -1, -1);
      tick(4);
    end
    // POP high in the cycle whose closing edge is the 5th stop sample.
    send_byte(8'h05, 1'b1, 1'b0, 16, STOP_EDGE - 1, -1, -1, -1);
    tick(4);
    total++;
    if (OVERRUN !== 1'b0 || RX_FULL !== 1'b1) begin
      bad++; $display("FAIL collide_flags: got ovr=%b full=%b want 0 1", OVERRUN, RX_FULL);
    end
    for (int i = 2; i <= 5; i++) begin
      total++;
      if (RDATA !== 8'(i)) begin bad++; $display("FAIL collide_pop%0d: got %h want %h", i, RDATA, 8'(i)); end
      pulse_pop();
    end
    total++;
    if (RX_READY !== 1'b0) begin bad++; $display("FAIL collide_empty: got ready=%b want 0", RX_READY); end
  endtask

  task automatic test_glitch_frame();
    logic busy_seen;
    RX = 1'b0; tick(4);
    total++;
    if (BUSY !== 1'b1) begin bad++; $display("FAIL glitch_busy: got %b want 1", BUSY); end
    RX = 1'b1; tick(20);
    total++;
    if (BUSY !== 1'b0 || RX_READY !== 1'b0) begin
      bad++; $display("FAIL glitch_abort: got busy=%b ready=%b want 0 0", BUSY, RX_READY);
    end
    // Bad stop bit with CLR_ERR in the same cycle: the set must win.
    send_byte(8'h3C, 1'b0, 1'b0, 16, -1, STOP_EDGE - 1, -1, -1);
    total++;
    if (FRAME_ERR !== 1'b1 || RX_READY !== 1'b0) begin
      bad++; $display("FAIL frame_err: got fe=%b ready=%b want 1 0", FRAME_ERR, RX_READY);
    end
    busy_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (BUSY) busy_seen = 1'b1;
    end
    total++;
    if (busy_seen !== 1'b0) begin bad++; $display("FAIL break_rearm: got busy=%b want 0", busy_seen); end
    RX = 1'b1; tick(4);
    send_byte(8'h3C, 1'b1, 1'b0, 16, -1, -1, -1, -1);
    tick(4);
    total++;
    if (RDATA !== 8'h3C || FRAME_ERR !== 1'b1) begin
      bad++; $display("FAIL after_break: got rdata=%h fe=%b want 3c 1", RDATA, FRAME_ERR);
    end
    CLR_ERR = 1'b1; tick(1); CLR_ERR = 1'b0;
    total++;
    if (FRAME_ERR !== 1'b0) begin bad++; $display("FAIL fe_clr: got %b want 0", FRAME_ERR); end
    pulse_pop();
  endtask

  task automatic test_divisor_disable();
    BAUD_DIV = 8'd3;
    send_byte(8'h81, 1'b1, 1'b0, 64, -1, -1, -1, -1);
    tick(8);
    total++;
    if (RX_READY !== 1'b1 || RDATA !== 8'h81) begin
      bad++; $display("FAIL div3_rdata: got ready=%b rdata=%h want 1 81", RX_READY, RDATA);
    end
    pulse_pop();
    BAUD_DIV = 8'd0;
    tick(4);
    // Edge 88 lies in the middle of data bit 4.
    send_byte(8'h7E, 1'b1, 1'b0, 16, -1, -1, 88, -1);
    tick(4);
    total++;
    if (busy_pre !== 1'b1 || busy_post !== 1'b0) begin
      bad++; $display("FAIL en_abort_busy: got pre=%b post=%b want 1 0", busy_pre, busy_post);
    end
    total++;
    if (RX_READY !== 1'b0) begin bad++; $display("FAIL en_abort_push: got ready=%b want 0", RX_READY); end
    EN = 1'b1; tick(4);
    send_byte(8'h7E, 1'b1, 1'b0, 16, -1, -1, -1, -1);
    tick(4);
    total++;
    if (RX_READY !== 1'b1 || RDATA !== 8'h7E) begin
      bad++; $display("FAIL reenable: got ready=%b rdata=%h want 1 7e", RX_READY, RDATA);
    end
    pulse_pop();
  endtask

  task automatic test_reset_midframe();
    // All-ones data keeps the line high after reset, so no false restart.
    send_byte(8'hFF, 1'b1, 1'b0, 16, -1, -1, -1, 40);
    tick(4);
    total++;
    if (RX_READY !== 1'b0 || BUSY !== 1'b0) begin
      bad++; $display("FAIL reset_midframe: got ready=%b busy=%b want 0 0", RX_READY, BUSY);
    end
  endtask

  task automatic test_parity();
    send_byte(8'h03, 1'b1, 1'b0, 16, -1, -1, -1, -1);
    tick(4);
    total++;
    if (RDATA !== 8'h03 || PARITY_ERR !== 1'b0) begin
      bad++; $display("FAIL parity_good: got rdata=%h pe=%b want 03 0", RDATA, PARITY_ERR);
    end
    pulse_pop();
`ifdef UART_RX_PARITY_EN
    send_byte(8'h03, 1'b1, 1'b1, 16, -1, -1, -1, -1);
    tick(4);
    total++;
    if (PARITY_ERR !== 1'b1 || RX_READY !== 1'b0) begin
      bad++; $display("FAIL parity_bad: got pe=%b ready=%b want 1 0", PARITY_ERR, RX_READY);
    end
    CLR_ERR = 1'b1; tick(1); CLR_ERR = 1'b0;
    total++;
    if (PARITY_ERR !== 1'b0) begin bad++; $display("FAIL parity_clr: got %b want 0", PARITY_ERR); end
`endif
  endtask

  initial begin
    test_reset();
    test_clean_byte();
    test_fifo_fill();
    test_back_to_back();
    test_glitch_frame();
    test_divisor_disable();
    test_reset_midframe();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side stage of the serial peripheral: 8N1 asynchronous receiver with 16x oversampling and a small FIFO.
- Consumes the RX pin and the baud divisor value held by the CPU-facing register block.
- Produces the byte, ready flag and error flags that the CPU read mux, status register and interrupt logic consume.
- Replaces ad-hoc receive logic with a buffered, error-reporting front end.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- OVERSAMPLE, 16, baud ticks per bit; even, at least 4.
- DIVW, 8, width of the baud divisor input.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  receiver enable (status register bit 0 region).
- RX  input  1  asynchronous serial line; idles high.
- BAUD_DIV  input  DIVW  oversample tick every BAUD_DIV+1 clocks.
- POP  input  1  one-cycle pulse; CPU read of the data register.
- CLR_ERR  input  1  clears OVERRUN and FRAME_ERR.
- RDATA  output  8  FIFO head (first-word fall-through).
- RX_READY  output  1  FIFO not empty.
- RX_FULL  output  1  FIFO holds DEPTH entries.
- OVERRUN  output  1  sticky: byte dropped because FIFO was full.
- FRAME_ERR  output  1  sticky: stop bit sampled low.
- BUSY  output  1  FSM not in IDLE.
- PARITY_ERR  output  1  sticky parity error; see Optional Feature.

Behaviour:
- Reset, taken at a rising CLK while RST=1:
  - FIFO emptied; pointers and count set to 0.
  - FSM to IDLE; baud and sample counters set to 0.
  - Synchronizer flops set to 1.
  - All flags 0; RDATA 0.
  - Reset mid-frame discards the partial byte.
- Input sync: RX passes through a 2-FF synchronizer to give rxs; rxs_d is rxs delayed one clock.
- Baud tick: counter runs 0..BAUD_DIV while EN=1; tick is a one-clock pulse at wrap. BAUD_DIV=0 gives a tick every clock.
- FSM states and transitions:
  - IDLE: on rxs_d=1 and rxs=0 (falling edge), go to START with the sample counter at 0. Only edges rearm, so a held-low line (break) does not retrigger.
  - START: the counter advances on tick. At count OVERSAMPLE/2-1, sample rxs. If 0, go to DATA with the counter and bit index at 0. If 1, treat as a glitch and return to IDLE.
  - DATA: sample at count OVERSAMPLE-1, i.e. each bit centre. Shift in LSB first. After bit index 7, go to STOP.
  - STOP: sample at count OVERSAMPLE-1.
    - rxs=1 and FIFO not full (or POP the same cycle): push the byte.
    - rxs=1 and FIFO full with no POP: drop the byte and set OVERRUN.
    - rxs=0: drop the byte and set FRAME_ERR.
    - In all cases return to IDLE in the same cycle.
- FIFO:
  - Push takes effect at the clock edge of the stop sample. RX_READY and RDATA update on the following cycle.
  - POP when empty is ignored.
  - Simultaneous push and pop: count unchanged. When full, this is accepted with no OVERRUN.
  - Pointers wrap modulo DEPTH.
  - RX_FULL = (count == DEPTH).
- Flags: OVERRUN and FRAME_ERR are sticky. CLR_ERR clears them. If CLR_ERR and a set event occur in the same cycle, the set wins.
- EN=0:
  - Baud counter is held at 0 and the FSM is forced to IDLE, so a frame in progress is aborted and discarded.
  - FIFO contents and flags are retained; POP still works.
- BAUD_DIV change mid-frame takes effect at the next baud counter wrap; the frame result is undefined but no lockup may occur.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one bit at OVERSAMPLE-1 counts.
  - Even parity over the 8 data bits plus the parity bit.
  - Mismatch sets PARITY_ERR (sticky, cleared by CLR_ERR); the byte is dropped at STOP.
  - Frame length is 11 bits.
- Undefined: no PARITY state; PARITY_ERR is tied to 0.

Test Plan:
- Clean byte: RST, EN=1, BAUD_DIV=0, drive 0xA5 as 8N1 at 16 clocks/bit -> RX_READY rises 152–158 clocks after the start edge; RDATA=0xA5. POP -> RX_READY=0 next cycle.
- FIFO fill/overrun: send 0x01..0x05 with no POP (DEPTH=4) -> RX_FULL=1 after 0x04, OVERRUN=1 after 0x05. Four POPs return 0x01,0x02,0x03,0x04. CLR_ERR -> OVERRUN=0.
- Push/pop collision: FIFO full; pulse POP in the exact cycle of the 5th stop sample -> OVERRUN stays 0; the FIFO then holds 0x02..0x05.
- Glitch and frame error: a 4-clock low pulse on RX -> BUSY returns to 0 and nothing is pushed. Byte 0x3C with stop bit low -> FRAME_ERR=1, FIFO empty; the line held low does not restart reception until it goes high then low.
- Divisor and disable: BAUD_DIV=3 (64 clocks/bit), send 0x81 -> RDATA=0x81. Drop EN during bit 4 of 0x7E -> BUSY=0 next cycle, no push; re-enable and send 0x7E -> received correctly.
- Parity (macro defined): 0x03 with parity bit 0 -> pushed. 0x03 with parity bit 1 -> PARITY_ERR=1, no push.
